axi4_slave_write_mem: RTL and testbench

AXI4 slave write-path responder. It accepts one write transaction at a time on the AW/W/B channels, stores the accepted bytes in an internal 256-byte memory and returns a write response. It is the DUT-side consumer of the master agent's write traffic and uses the shared AXI4 globals package widths, burst/size encodings and response codes. A combinational debug read port lets the bench check memory contents.

---
 rtl/axi4_slave_write_mem.sv | 174 +++++++++++++++++
 tb/tb_axi4_slave_write_mem.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_write_mem.sv
// AXI4 write-path slave: one transaction at a time over AW/W/B into a 256-byte memory.
// A combinational debug port reads four little-endian bytes with address wrap.
module axi4_slave_write_mem #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 8,
  parameter int LENGTH        = 8,
  parameter int STROBE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ID_WIDTH-1:0]      awid,
  input  logic [ADDRESS_WIDTH-1:0] awaddr,
  input  logic [LENGTH-1:0]        awlen,
  input  logic [2:0]               awsize,
  input  logic [1:0]               awburst,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [STROBE_WIDTH-1:0]  wstrb,
  input  logic                     wlast,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [ID_WIDTH-1:0]      bid,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ADDRESS_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]    dbg_rdata,
  output logic [1:0]               dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and B outputs hold stable until bready.

  localparam int LB    = $clog2(STROBE_WIDTH);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                   state_q;
  logic [ID_WIDTH-1:0]      id_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH-1:0] addr_d;
  logic [LENGTH-1:0]        len_q;
  logic [LENGTH-1:0]        cnt_q;
  logic [2:0]               size_q;
  logic [1:0]               burst_q;
  logic                     err_q;
  logic                     awready_q;
  logic                     wready_q;
  logic                     bvalid_q;
  logic [ID_WIDTH-1:0]      bid_q;
  logic [1:0]               bresp_q;

  logic [7:0]               mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] sz_w;
  logic [ADDRESS_WIDTH-1:0] base_w;
  logic [STROBE_WIDTH-1:0]  lane_we;
  logic                     beat;
  logic                     len_hit;
  logic                     burst_end;

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign dbg_state = state_q;

  assign beat      = (state_q == S_DATA) && wvalid && wready_q;
  assign len_hit   = (cnt_q == len_q);
  assign burst_end = len_hit || wlast;

  // Lanes below the start offset or beyond the aligned beat window are never written.
  always_comb begin
    sz_w    = ADDRESS_WIDTH'(1) << size_q;
    base_w  = addr_q & ~(sz_w - ADDRESS_WIDTH'(1));
    addr_d  = (burst_q == 2'b01) ? (base_w + sz_w) : addr_q;
    lane_we = '0;
    for (int i = 0; i < STROBE_WIDTH; i++) begin
      lane_we[i] = wstrb[i] && (i >= int'(addr_q[LB-1:0])) &&
                   (i < int'(base_w[LB-1:0]) + int'(sz_w));
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= 3'd0;
      burst_q   <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (awvalid && awready_q) begin
            id_q      <= awid;
            addr_q    <= awaddr;
            len_q     <= awlen;
            size_q    <= awsize;
            burst_q   <= awburst;
            cnt_q     <= '0;
            err_q     <= awburst[1] || (awsize > 3'd2);
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            state_q   <= S_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        S_DATA: begin
          if (beat) begin
            cnt_q  <= cnt_q + LENGTH'(1);
            addr_q <= addr_d;
            if (burst_end) begin
              // wlast disagreeing with the beat count is a protocol error.
              err_q    <= err_q || (wlast != len_hit);
              bresp_q  <= (err_q || (wlast != len_hit)) ? 2'b10 : 2'b00;
              bid_q    <= id_q;
              bvalid_q <= 1'b1;
              wready_q <= 1'b0;
              state_q  <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  // Memory has no reset so contents survive aresetn.
  always_ff @(posedge aclk) begin
    if (aresetn && beat && !err_q) begin
      for (int i = 0; i < STROBE_WIDTH; i++) begin
        if (lane_we[i]) begin
          mem[{addr_q[ADDRESS_WIDTH-1:LB], LB'(i)}] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    dbg_rdata = '0;
    for (int i = 0; i < STROBE_WIDTH; i++) begin
      dbg_rdata[8*i +: 8] = mem[dbg_addr + ADDRESS_WIDTH'(i)];
    end
  end

endmodule

// File: tb/tb_axi4_slave_write_mem.sv
// Directed bench for axi4_slave_write_mem: bursts, wrap, error responses, B stall and reset.
module tb_axi4_slave_write_mem;

  logic        aclk;
  logic        aresetn;
  logic [7:0]  awid;
  logic [7:0]  awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_rdata;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  axi4_slave_write_mem dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change at negedge or 1ns after posedge.
  task automatic aw_send(input logic [7:0] id, input logic [7:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge aclk); n++; end
    if (!awready) chk("aw_timeout", {31'd0, awready}, 32'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n;
    @(negedge aclk);
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    n = 0;
    while (!wready && n < 20) begin @(negedge aclk); n++; end
    if (!wready) chk("w_timeout", {31'd0, wready}, 32'd1);
    @(posedge aclk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_take(input string tag, input logic [7:0] exp_id, input logic [1:0] exp_resp);
    int n;
    @(negedge aclk);
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge aclk); n++; end
    chk({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
    chk({tag, "_bid"}, {24'd0, bid}, {24'd0, exp_id});
    chk({tag, "_bresp"}, {30'd0, bresp}, {30'd0, exp_resp});
    @(posedge aclk); #1;
    bready = 1'b0;
    chk({tag, "_bvalid_drop"}, {31'd0, bvalid}, 32'd0);
    chk({tag, "_awready_back"}, {31'd0, awready}, 32'd1);
  endtask

  task automatic mem_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    @(negedge aclk);
    dbg_addr = addr;
    #1;
    chk(tag, dbg_rdata, exp);
  endtask

  initial begin
    aresetn = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    awvalid = 1'b1; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    dbg_addr = '0;

    // Reset with awvalid high
    repeat (3) @(negedge aclk);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready", {31'd0, wready}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_bid", {24'd0, bid}, 32'd0);
    aresetn = 1'b1; awvalid = 1'b0;
    @(posedge aclk); #1;
    chk("rel_awready", {31'd0, awready}, 32'd1);
    chk("rel_state", {30'd0, dbg_state}, 32'd0);

    // W before AW is not consumed
    @(negedge aclk);
    wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    repeat (2) @(negedge aclk);
    chk("early_w_wready", {31'd0, wready}, 32'd0);
    chk("early_w_state", {30'd0, dbg_state}, 32'd0);
    wvalid = 1'b0;

    // INCR 4 beats, word size
    aw_send(8'h05, 8'h10, 8'd3, 3'd2, 2'b01);
    chk("incr_wready_lat", {31'd0, wready}, 32'd1);
    w_beat(32'h1111_1111, 4'hF, 1'b0);
    w_beat(32'h2222_2222, 4'hF, 1'b0);
    w_beat(32'h3333_3333, 4'hF, 1'b0);
    w_beat(32'h4444_4444, 4'hF, 1'b1);
    chk("incr_bvalid_lat", {31'd0, bvalid}, 32'd1);
    chk("incr_wready_off", {31'd0, wready}, 32'd0);
    b_take("incr", 8'h05, 2'b00);
    mem_chk("incr_m10", 8'h10, 32'h1111_1111);
    mem_chk("incr_m14", 8'h14, 32'h2222_2222);
    mem_chk("incr_m18", 8'h18, 32'h3333_3333);
    mem_chk("incr_m1c", 8'h1C, 32'h4444_4444);

    // Background word, then FIXED byte bursts into 0x21
    aw_send(8'h06, 8'h20, 8'd0, 3'd2, 2'b01);
    w_beat(32'h5566_7788, 4'hF, 1'b1);
    b_take("bg", 8'h06, 2'b00);
    aw_send(8'h07, 8'h21, 8'd1, 3'd0, 2'b00);
    w_beat(32'h0000_AA00, 4'hF, 1'b0);
    w_beat(32'h0000_BB00, 4'hF, 1'b1);
    b_take("fixed", 8'h07, 2'b00);
    mem_chk("fixed_m20", 8'h20, 32'h5566_BB88);

    // INCR halfword across the top of memory
    aw_send(8'h08, 8'hFE, 8'd1, 3'd1, 2'b01);
    w_beat(32'hCCDD_0000, 4'hF, 1'b0);
    w_beat(32'h0000_2211, 4'hF, 1'b1);
    b_take("wrap", 8'h08, 2'b00);
    mem_chk("wrap_mfe", 8'hFE, 32'h2211_CCDD);

    // Unsupported burst type: accepted but not written
    aw_send(8'h09, 8'h10, 8'd0, 3'd2, 2'b10);
    w_beat(32'hDEAD_BEEF, 4'hF, 1'b1);
    b_take("badburst", 8'h09, 2'b10);
    mem_chk("badburst_m10", 8'h10, 32'h1111_1111);

    // Oversized awsize: SLVERR, no write
    aw_send(8'h0A, 8'h14, 8'd0, 3'd3, 2'b01);
    w_beat(32'h0BAD_0BAD, 4'hF, 1'b1);
    b_take("badsize", 8'h0A, 2'b10);
    mem_chk("badsize_m14", 8'h14, 32'h2222_2222);

    // Early wlast on beat 1 of 4
    aw_send(8'h0B, 8'h30, 8'd3, 3'd2, 2'b01);
    w_beat(32'hA0A0_A0A0, 4'hF, 1'b0);
    w_beat(32'hB1B1_B1B1, 4'hF, 1'b1);
    chk("early_bvalid", {31'd0, bvalid}, 32'd1);
    chk("early_wready", {31'd0, wready}, 32'd0);
    b_take("early", 8'h0B, 2'b10);

    // Missing wlast on the final beat
    aw_send(8'h0C, 8'h34, 8'd0, 3'd2, 2'b01);
    w_beat(32'hC2C2_C2C2, 4'hF, 1'b0);
    chk("nolast_state", {30'd0, dbg_state}, 32'd2);
    b_take("nolast", 8'h0C, 2'b10);

    // Partial strobes
    aw_send(8'h0D, 8'h40, 8'd0, 3'd2, 2'b01);
    w_beat(32'h1234_5678, 4'h5, 1'b1);
    b_take("strb", 8'h0D, 2'b00);
    aw_send(8'h0E, 8'h40, 8'd0, 3'd2, 2'b01);
    w_beat(32'hAABB_CCDD, 4'hA, 1'b1);
    b_take("strb2", 8'h0E, 2'b00);
    mem_chk("strb_m40", 8'h40, 32'hAA34_CC78);

    // B stall for 5 cycles
    aw_send(8'h3C, 8'h44, 8'd0, 3'd2, 2'b01);
    w_beat(32'h0F0F_0F0F, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("stall_bvalid", {31'd0, bvalid}, 32'd1);
      chk("stall_bid", {24'd0, bid}, 32'h3C);
      chk("stall_bresp", {30'd0, bresp}, 32'd0);
      chk("stall_awready", {31'd0, awready}, 32'd0);
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    chk("stall_bvalid_drop", {31'd0, bvalid}, 32'd0);
    chk("stall_state_idle", {30'd0, dbg_state}, 32'd0);
    chk("stall_awready_back", {31'd0, awready}, 32'd1);

    // Reset mid-DATA drops the transaction but keeps memory
    aw_send(8'h3D, 8'h50, 8'd3, 3'd2, 2'b01);
    w_beat(32'h8765_4321, 4'hF, 1'b0);
    @(negedge aclk);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    chk("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    chk("mid_rst_wready", {31'd0, wready}, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    bready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("mid_rst_no_b", {31'd0, bvalid}, 32'd0);
    chk("mid_rst_awready", {31'd0, awready}, 32'd1);
    bready = 1'b0;
    mem_chk("mid_rst_m50", 8'h50, 32'h8765_4321);
    mem_chk("mid_rst_m10", 8'h10, 32'h1111_1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
